// File: rtl/lock_sequencer.sv
// Lock-acquisition controller: sweeps until a fringe is seen, engages the PID,
// qualifies lock over a settle window and latches a fault after repeated failed captures.
module lock_sequencer #(
  parameter int W             = 16,
  parameter int SETTLE_CYCLES = 100000000,
  parameter int LOSS_CYCLES   = 16,
  parameter int MAX_RETRY     = 8,
  parameter int CW            = 28
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                enable_in,
  input  logic                clear_fault_in,
  input  logic signed [W-1:0] trans_in,
  input  logic signed [W-1:0] thresh_lock_in,
  input  logic signed [W-1:0] thresh_unlock_in,
  output logic                sweep_on_out,
  output logic                sweep_hold_out,
  output logic                pid_on_out,
  output logic                pid_clear_out,
  output logic                locked_out,
  output logic                fault_out,
  output logic [2:0]          state_out,
  output logic [7:0]          relock_count_out
);

  localparam int LW = $clog2(LOSS_CYCLES + 1);
  localparam int AW = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_CYCLES - 1);
  localparam logic [AW-1:0] RETRY_MAX   = AW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_SWEEP   = 3'b001,
    ST_CAPTURE = 3'b010,
    ST_LOCKED  = 3'b011,
    ST_FAULT   = 3'b100
  } state_t;

  state_t        state_q;
  logic          hi_q;
  logic          lo_q;
  logic [CW-1:0] settle_q;
  logic [LW-1:0] loss_q;
  logic [AW-1:0] attempts_q;
  logic [7:0]    relock_q;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
      settle_q   <= '0;
      loss_q     <= '0;
      attempts_q <= '0;
      relock_q   <= '0;
    end else begin
      hi_q <= (trans_in >= thresh_lock_in);
      lo_q <= (trans_in <  thresh_unlock_in);

      unique case (state_q)
        ST_IDLE: begin
          if (enable_in) state_q <= ST_SWEEP;
        end

        ST_SWEEP: begin
          settle_q <= '0;
          loss_q   <= '0;
          if (!enable_in) begin
            state_q    <= ST_IDLE;
            attempts_q <= '0;
          end else if (hi_q) begin
            state_q <= ST_CAPTURE;
          end
        end

        // attempts_q counts captures lost before settling; the LOCKED loss path
        // does not touch it, so a fault needs MAX_RETRY+1 consecutive failures.
        ST_CAPTURE: begin
          if (!enable_in) begin
            state_q    <= ST_IDLE;
            attempts_q <= '0;
            settle_q   <= '0;
            loss_q     <= '0;
          end else if (lo_q) begin
            if (loss_q == LOSS_LAST) begin
              loss_q <= '0;
              if (attempts_q == RETRY_MAX) begin
                state_q <= ST_FAULT;
              end else begin
                state_q    <= ST_SWEEP;
                attempts_q <= attempts_q + 1'b1;
              end
            end else begin
              loss_q <= loss_q + 1'b1;
            end
          end else begin
            loss_q <= '0;
            if (settle_q == SETTLE_LAST) begin
              state_q    <= ST_LOCKED;
              attempts_q <= '0;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
        end

        ST_LOCKED: begin
          if (!enable_in) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            loss_q   <= '0;
          end else if (lo_q) begin
            if (loss_q == LOSS_LAST) begin
              state_q <= ST_SWEEP;
              loss_q  <= '0;
              if (relock_q != 8'hFF) relock_q <= relock_q + 1'b1;
            end else begin
              loss_q <= loss_q + 1'b1;
            end
          end else begin
            loss_q <= '0;
          end
        end

        ST_FAULT: begin
          if (clear_fault_in) begin
            state_q    <= ST_IDLE;
            attempts_q <= '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore decode straight off the state register keeps trans->output at two edges.
  // NOTE: every output gets a default before the case so no latch can be inferred.
  always_comb begin
    sweep_on_out   = 1'b0;
    sweep_hold_out = 1'b0;
    pid_on_out     = 1'b0;
    pid_clear_out  = 1'b1;
    locked_out     = 1'b0;
    fault_out      = 1'b0;
    unique case (state_q)
      ST_SWEEP: sweep_on_out = 1'b1;
      ST_CAPTURE, ST_LOCKED: begin
        sweep_on_out   = 1'b1;
        sweep_hold_out = 1'b1;
        pid_on_out     = 1'b1;
        pid_clear_out  = 1'b0;
        locked_out     = (state_q == ST_LOCKED);
      end
      ST_FAULT: fault_out = 1'b1;
      default: ;
    endcase
  end

  assign state_out        = state_q;
  assign relock_count_out = relock_q;

endmodule
